// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: ownership states and requester indices.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    typedef logic req_idx_t;

    localparam req_idx_t CPU_IDX = 1'b0;
    localparam req_idx_t DMA_IDX = 1'b1;

endpackage

// File: rtl/dmem_rsp_reg.sv
// Per-requester read response register: captures memory read data one cycle
// after a granted read and pulses rvalid for exactly that cycle.
module dmem_rsp_reg #(
    parameter int M = 32
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         cap_en,
    input  logic [M-1:0] mem_rd,
    output logic         rvalid,
    output logic [M-1:0] rd
);

    logic         rvalid_r;
    logic [M-1:0] rd_r;

    // Read-data capture; data holds its value when no read completes
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rvalid_r <= 1'b0;
            rd_r     <= {M{1'b0}};
        end else begin
            rvalid_r <= cap_en;
            if (cap_en) begin
                rd_r <= mem_rd;
            end else begin
                rd_r <= rd_r;
            end
        end
    end

    assign rvalid = rvalid_r;
    assign rd     = rd_r;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory, with bounded
// locked ownership. Define DMEM_ARB_RR_EN for round-robin contention, else fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int M        = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         REQ0,
    input  logic         LOCK0,
    input  logic         WE0,
    input  logic [M-1:0] A0,
    input  logic [M-1:0] WD0,
    output logic         GNT0,
    output logic         RVALID0,
    output logic [M-1:0] RD0,
    input  logic         REQ1,
    input  logic         LOCK1,
    input  logic         WE1,
    input  logic [M-1:0] A1,
    input  logic [M-1:0] WD1,
    output logic         GNT1,
    output logic         RVALID1,
    output logic [M-1:0] RD1,
    output logic         MEM_WE,
    output logic [M-1:0] MEM_A,
    output logic [M-1:0] MEM_WD,
    input  logic [M-1:0] MEM_RD
);

    localparam int            HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

    state_t        state_r, next_state_s;
    logic [HW-1:0] hold_cnt_r, next_hold_s;
    logic          keep_s, own_lock_s, fav1_s, idle_fav1_s;
    logic          gnt0_s, gnt1_s;

    // Ownership state and consecutive locked-beat counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= IDLE;
            hold_cnt_r <= {HW{1'b0}};
        end else begin
            state_r    <= next_state_s;
            hold_cnt_r <= next_hold_s;
        end
    end

`ifdef DMEM_ARB_RR_EN
    req_idx_t rr_last_r;

    // Most recent winner; the other requester is favoured on the next contention
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rr_last_r <= DMA_IDX;
        end else if (gnt0_s) begin
            rr_last_r <= CPU_IDX;
        end else if (gnt1_s) begin
            rr_last_r <= DMA_IDX;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

    assign idle_fav1_s = (rr_last_r == CPU_IDX);
`else
    assign idle_fav1_s = 1'b0;
`endif

    // Owner keeps the port while it requests and its hold budget lasts
    always_comb begin
        keep_s     = 1'b0;
        own_lock_s = 1'b0;
        fav1_s     = idle_fav1_s;
        case (state_r)
            OWN0: begin
                keep_s     = REQ0 && (hold_cnt_r < HOLD_LIM);
                own_lock_s = LOCK0;
                fav1_s     = 1'b1;
            end
            OWN1: begin
                keep_s     = REQ1 && (hold_cnt_r < HOLD_LIM);
                own_lock_s = LOCK1;
                fav1_s     = 1'b0;
            end
            default: begin
                keep_s     = 1'b0;
                own_lock_s = 1'b0;
                fav1_s     = idle_fav1_s;
            end
        endcase
    end

    // Grant selection: kept owner, else favoured requester on contention
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (keep_s) begin
            gnt0_s = (state_r == OWN0);
            gnt1_s = (state_r == OWN1);
        end else if (REQ0 && REQ1) begin
            gnt0_s = !fav1_s;
            gnt1_s = fav1_s;
        end else begin
            gnt0_s = REQ0;
            gnt1_s = REQ1;
        end
    end

    // Next ownership: a fresh owner starts its hold count at zero
    always_comb begin
        next_state_s = IDLE;
        next_hold_s  = {HW{1'b0}};
        if (keep_s && own_lock_s) begin
            next_state_s = state_r;
            next_hold_s  = hold_cnt_r + HW'(1);
        end else if (keep_s) begin
            next_state_s = IDLE;
        end else if (gnt0_s && LOCK0) begin
            next_state_s = OWN0;
        end else if (gnt1_s && LOCK1) begin
            next_state_s = OWN1;
        end else begin
            next_state_s = IDLE;
        end
    end

    // Memory port steering from the granted requester
    always_comb begin
        MEM_WE = 1'b0;
        MEM_A  = {M{1'b0}};
        MEM_WD = {M{1'b0}};
        if (gnt0_s) begin
            MEM_WE = WE0;
            MEM_A  = A0;
            MEM_WD = WD0;
        end else if (gnt1_s) begin
            MEM_WE = WE1;
            MEM_A  = A1;
            MEM_WD = WD1;
        end else begin
            MEM_WE = 1'b0;
        end
    end

    assign GNT0 = gnt0_s;
    assign GNT1 = gnt1_s;

    dmem_rsp_reg #(.M(M)) u_rsp0 (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .cap_en (gnt0_s && !WE0),
        .mem_rd (MEM_RD),
        .rvalid (RVALID0),
        .rd     (RD0)
    );

    dmem_rsp_reg #(.M(M)) u_rsp1 (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .cap_en (gnt1_s && !WE1),
        .mem_rd (MEM_RD),
        .rvalid (RVALID1),
        .rd     (RD1)
    );

endmodule
